log_record_reader: RTL
======================

// Module: log_record_reader
// PURPOSE
// - Consumer end of the in-design logging path. Instrumented logic produces per-cycle log records
//   (level + payload); this block filters them, buffers them and hands them to a reader.
// - Level filter: records below a runtime minimum level are discarded.
// - Accepted records go into a DEPTH-entry FIFO and drain through a valid/ready read port.
// - Records arriving while the FIFO is full are counted as drops.
// PARAMETERS
// - DATA_W   default 16  payload width per record, >=1
// - DEPTH    default 8   FIFO entries; power of two, >=2
// - CNT_W    default 8   drop-counter width; counter saturates
// - TS_W     default 32  timestamp width; used only with LOG_READER_TIMESTAMP_EN
// PORTS
// - CLK          in   1        clock, rising edge
// - ASYNCRESETN  in   1        asynchronous, active-low reset
// - CE           in   1        capture enable; records are sampled only when CE=1
// - min_level    in   2        filter threshold: 0=DEBUG 1=INFO 2=WARNING 3=ERROR
// - rec_valid    in   1        record present this cycle
// - rec_level    in   2        record level, same encoding as min_level
// - rec_data     in   DATA_W   record payload
// - rd_valid     out  1        head record available
// - rd_ready     in   1        reader accepts head record
// - rd_level     out  2        head record level
// - rd_data      out  DATA_W   head record payload
// - count        out  clog2(DEPTH)+1  current occupancy
// - drop_cnt     out  CNT_W    saturating count of dropped records
// - drop_clr     in   1        synchronous clear of drop_cnt
// BEHAVIOUR
// - Reset (ASYNCRESETN=0, asynchronous)
//   - Pointers, count and drop_cnt go to 0; rd_valid=0.
//   - rd_level/rd_data are don't-care while rd_valid=0.
// - Capture
//   - cap = CE & rec_valid & (rec_level >= min_level), unsigned compare.
//   - Records with cap=0 are ignored and are not counted as drops.
// - Push: cap & (!full | pop). When full and popping in the same cycle, the push is accepted
//   and count is unchanged.
// - Pop: rd_valid & rd_ready. No pop occurs when empty, whatever rd_ready does.
// - Read port (first-word fall-through)
//   - rd_valid = (count != 0).
//   - rd_level/rd_data show the head entry combinationally from storage.
//   - A record written at edge N is visible on rd_valid after edge N (latency 1).
//   - Head entry and rd_valid stay stable until the record is popped.
// - Pointers: wr_ptr and rd_ptr are clog2(DEPTH) bits and wrap modulo DEPTH.
//   count update: +1 push only, -1 pop only, unchanged for both or neither.
// - Drops
//   - A drop is cap & full & !pop.
//   - drop_cnt increments on each drop and saturates at 2^CNT_W-1.
//   - drop_clr & drop in the same cycle sets drop_cnt=1; drop_clr alone sets it to 0.
// - min_level may change at any cycle and takes effect on the same-cycle capture decision.
// - Reset asserted mid-stream discards all buffered records immediately; no partial state survives.
// CONFIGURATION
// - LOG_READER_TIMESTAMP_EN defined
//   - Adds output rd_timestamp [TS_W-1:0] and a free-running TS_W-bit cycle counter.
//   - The counter resets to 0 and increments every CLK, independent of CE, and wraps.
//   - Each pushed record stores the counter value at its capture edge.
//   - rd_timestamp shows the head entry's stored value under the same rules as rd_data.
// - Undefined: no counter, no timestamp storage, no rd_timestamp port.
//   All other behaviour is identical.
// TESTING
// - Reset then idle: count=0, rd_valid=0, drop_cnt=0. Release reset; still empty after 5 cycles.
// - Filter: min_level=2; push levels 0,1,2,3 with data 0x11,0x22,0x33,0x44 at CE=1.
//   Pops return exactly (2,0x33) then (3,0x44). CE=0 with level 3 stores nothing.
// - Full/drop: DEPTH=8, min_level=0, rd_ready=0; push 10 records.
//   Result: count=8, drop_cnt=2, head is the first record. Drain; order is preserved.
// - Simultaneous push and pop at full, rd_ready=1 with a new record:
//   count stays 8, drop_cnt unchanged, newest record is read last.
// - Saturation/clear: CNT_W=2; cause 5 drops -> drop_cnt=3.
//   drop_clr together with a drop -> drop_cnt=1.
// - Mid-stream reset: after 3 pushes, pulse ASYNCRESETN low between edges.
//   rd_valid=0 and count=0 immediately.
//   With LOG_READER_TIMESTAMP_EN, records pushed at cycles 4 and 7 after reset
//   read back rd_timestamp=4 and 7.

Source files
------------

// File: rtl/log_record_reader.sv
// Level-filtered log record FIFO with a first-word fall-through read port and saturating drop counter.
// Optional per-record capture timestamps are enabled with LOG_READER_TIMESTAMP_EN.
module log_record_reader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8,
    parameter int TS_W   = 32
) (
    input  logic                      CLK,
    input  logic                      ASYNCRESETN,
    input  logic                      CE,
    input  logic [1:0]                min_level,
    input  logic                      rec_valid,
    input  logic [1:0]                rec_level,
    input  logic [DATA_W-1:0]         rec_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [1:0]                rd_level,
    output logic [DATA_W-1:0]         rd_data,
`ifdef LOG_READER_TIMESTAMP_EN
    output logic [TS_W-1:0]           rd_timestamp,
`endif
    output logic [$clog2(DEPTH):0]    count,
    output logic [CNT_W-1:0]          drop_cnt,
    input  logic                      drop_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DROP_MAX = '1;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [1:0]        lvl_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic full;
    logic cap;
    logic pop;
    logic push;
    logic drop;

    // Read handshake: a record transfers on any cycle where rd_valid and rd_ready are both high;
    // rd_valid never depends on rd_ready, and the head stays put until it transfers.
    assign rd_valid = (count != '0);
    assign full     = (count == FULL_CNT);
    assign cap      = CE & rec_valid & (rec_level >= min_level);
    assign pop      = rd_valid & rd_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push     = cap & (~full | pop);
    assign drop     = cap & full & ~pop;

    assign rd_level = lvl_mem[rd_ptr];
    assign rd_data  = data_mem[rd_ptr];

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A clear coinciding with a drop keeps that drop rather than losing it.
            if (drop_clr)
                drop_cnt <= drop ? DROP_ONE : '0;
            else if (drop && drop_cnt != DROP_MAX)
                drop_cnt <= drop_cnt + DROP_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            lvl_mem[wr_ptr]  <= rec_level;
            data_mem[wr_ptr] <= rec_data;
        end
    end

`ifdef LOG_READER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_mem [DEPTH];

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) ts_cnt <= '0;
        else              ts_cnt <= ts_cnt + TS_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (push) ts_mem[wr_ptr] <= ts_cnt;
    end

    assign rd_timestamp = ts_mem[rd_ptr];
`endif

endmodule
